// File: rtl/mlp_pkg.sv
// Shared MLP definitions: default fixed-point format used by the
// dot-product engine, loaders and writer, plus the writer FSM states.
package mlp_pkg;

    localparam int DATA_WIDTH_DEF     = 27;
    localparam int FRACTION_WIDTH_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // Width of a counter that indexes n entries (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_relu.sv
// Combinational ReLU on one signed fixed-point word.
// Ports: en (clamp enable), din (signed word), dout (din, or 0 if negative).
module mlp_relu
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    // Sign bit alone decides; the most negative value also maps to 0.
    assign dout = (en && din[DATA_WIDTH-1]) ? '0 : din;

endmodule

// File: rtl/mlp_vec_writer.sv
// Snapshots VEC_SIZE engine results (optional ReLU) and streams them
// into the next layer's vector RAM starting at wr_base.
// Ports: clk, rst (sync, active high), start, result_in (flattened
// words), wr_base, wr_ready -> wr_en, wr_addr, wr_data, busy, done.
module mlp_vec_writer
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int FRACTION_WIDTH = FRACTION_WIDTH_DEF,
    parameter int VEC_SIZE       = 10,
    parameter int ADDR_WIDTH     = 4,
    parameter bit RELU_EN        = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [VEC_SIZE*DATA_WIDTH-1:0] result_in,
    input  logic [ADDR_WIDTH-1:0]          wr_base,
    input  logic                           wr_ready,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = cnt_width(VEC_SIZE);
    localparam logic [CW-1:0] LAST = CW'(VEC_SIZE - 1);

    // Parameter sanity checks at elaboration.
    if (VEC_SIZE < 1) begin : g_chk_size
        $error("mlp_vec_writer: VEC_SIZE must be >= 1");
    end
    if ((1 << ADDR_WIDTH) < VEC_SIZE) begin : g_chk_addr
        $error("mlp_vec_writer: address space smaller than VEC_SIZE");
    end
    if (FRACTION_WIDTH >= DATA_WIDTH) begin : g_chk_frac
        $error("mlp_vec_writer: FRACTION_WIDTH must be < DATA_WIDTH");
    end

    wr_state_e             state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] snap     [VEC_SIZE];
    logic [DATA_WIDTH-1:0] relu_out [VEC_SIZE];

    for (genvar k = 0; k < VEC_SIZE; k++) begin : g_relu
        mlp_relu #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_relu (
            .en  (RELU_EN),
            .din (result_in[k*DATA_WIDTH +: DATA_WIDTH]),
            .dout(relu_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            base  <= '0;
            for (int k = 0; k < VEC_SIZE; k++) begin
                snap[k] <= '0;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < VEC_SIZE; k++) begin
                            snap[k] <= relu_out[k];
                        end
                        base  <= wr_base;
                        cnt   <= '0;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (cnt == LAST) begin
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only; wr_ready never
    // reaches the address or data path.
    assign wr_en   = (state == ST_WRITE);
    assign busy    = (state == ST_WRITE);
    assign done    = (state == ST_DONE);
    assign wr_addr = wr_en ? base + ADDR_WIDTH'(cnt) : '0;
    assign wr_data = wr_en ? snap[cnt] : '0;

endmodule

// File: doc/mlp_vec_writer.md
Name: mlp_vec_writer

Overview:
- Write-side counterpart of the MLP matrix-vector engine's vector read port.
- On start, snapshots the engine's VEC_SIZE result words and applies optional ReLU.
- Streams the words, one per accepted cycle, into the vector RAM for the next layer, starting at a programmable base address.
- Sits between the dot-product engine's result outputs and the RAM write port, and pulses done when the last word is accepted.

Parameters:
- DATA_WIDTH, 27, fixed-point word width including sign bit.
- FRACTION_WIDTH, 9, fraction bits; carried only for package consistency, no rescaling.
- VEC_SIZE, 10, number of result words per transfer (>=1).
- ADDR_WIDTH, 4, RAM address width; must satisfy 2^ADDR_WIDTH >= VEC_SIZE.
- RELU_EN, 1, 1 = clamp negative words to 0 before writing; 0 = pass through.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  level or pulse; sampled only in IDLE.
- result_in  input  VEC_SIZE*DATA_WIDTH  flattened signed results; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_base  input  ADDR_WIDTH  first RAM address; sampled with start.
- wr_ready  input  1  RAM/arbiter accepts the current write this cycle.
- wr_en  output  1  write request valid.
- wr_addr  output  ADDR_WIDTH  write address.
- wr_data  output  DATA_WIDTH  write data (signed).
- busy  output  1  high in WRITE.
- done  output  1  one-cycle pulse after the final accepted write.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, word counter=0, snapshot registers=0.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - Reset mid-transfer aborts: wr_en is low the cycle after the reset edge, and no further writes occur.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If start=1: capture all VEC_SIZE words of result_in into the snapshot (post-ReLU when RELU_EN=1), capture wr_base, clear the counter, and go to WRITE.
  - Otherwise stay in IDLE. Outputs low.
- WRITE:
  - wr_en=1, busy=1.
  - wr_addr = base + cnt, modulo 2^ADDR_WIDTH (wrap-around permitted, no error).
  - wr_data = snapshot[cnt].
  - If wr_ready=1 and cnt < VEC_SIZE-1: cnt increments.
  - If wr_ready=1 and cnt = VEC_SIZE-1: go to DONE.
  - If wr_ready=0: addr, data and cnt hold (stall of any length, write request stays asserted).
- DONE:
  - done=1, wr_en=0, busy=0, for exactly one cycle; then go to IDLE unconditionally.
- Latency:
  - First wr_en is asserted 1 cycle after the start edge.
  - With wr_ready held high, done asserts VEC_SIZE+1 cycles after the start edge.
- start in WRITE or DONE is ignored.
- start held high through DONE re-triggers on the IDLE cycle that follows, giving a back-to-back transfer with 1 idle cycle.
- result_in changes after capture have no effect on an ongoing transfer.
- Outputs wr_en, wr_addr and wr_data are driven combinationally from registered state, counter and snapshot; no combinational path from wr_ready to wr_addr or wr_data.
- ReLU:
  - Sign bit (MSB) = 1 -> 0.
  - Otherwise the word is unchanged; no width change, no saturation.
  - The most negative value maps to 0.
- VEC_SIZE=1: a single write, then done.
- wr_ready is a don't-care outside WRITE.

Decomposition:
- Shared package mlp_pkg:
  - state enum (IDLE/WRITE/DONE) for the writer.
  - Default DATA_WIDTH / FRACTION_WIDTH constants shared with the dot-product engine and loaders.
- One sub-module, mlp_relu: combinational, parameterised by DATA_WIDTH with an enable.
  - VEC_SIZE instances are generated at the snapshot input.
- Counter and FSM stay in the top module.

Test Plan:
- Basic transfer: RELU_EN=1, VEC_SIZE=10, wr_base=0, wr_ready=1, result_in words k = (k-5)*512 (i.e. -5.0 .. 4.0), start pulse -> addrs 0..9 written in 10 consecutive cycles. Data is 0 for k=0..5, then 512, 1024, 1536, 2048. done pulses once in cycle 11 after start, busy is high for exactly 10 cycles.
- Backpressure: toggle wr_ready 1,0,0,1,... during transfer -> each address is written exactly once with its data held across stalls. No address skipped or repeated on accepted cycles; done only after the 10th accepted write.
- Wrap-around: wr_base=12, ADDR_WIDTH=4 -> addresses 12,13,14,15,0,1,...,5 in order.
- Snapshot isolation and start ignore: change result_in and pulse start while in WRITE -> written data equals the values captured at the original start; no second transfer begins.
- Reset mid-operation: assert rst after the 4th accepted write -> wr_en=0, busy=0, done=0 from the next cycle, with no further writes. A new start afterwards performs a full 10-word transfer from the new wr_base.
- Pass-through and back-to-back: RELU_EN=0, result_in word 0 = -1 (all ones) -> written as all ones. start held high produces two transfers separated by exactly 1 IDLE cycle, with done pulsing twice.
